// File: rtl/jtag_vector_player_pkg.sv
// Shared types and constants for the JTAG vector player and its TCK generator.
package jtag_vector_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_STORE
    } state_e;

    localparam int FETCH_CYCLES  = 2;
    localparam int BITS_PER_BYTE = 4;
    localparam int TMS_BIT       = 0;
    localparam int TDI_BIT       = 1;

    // Each vector byte packs four {tdi, tms} pairs; returns the pair for one lane.
    function automatic logic [1:0] lane_pins(input logic [7:0] vec, input logic [1:0] lane);
        logic [2:0] base;
        base = {lane, 1'b0};
        return {vec[base + 3'(TDI_BIT)], vec[base + 3'(TMS_BIT)]};
    endfunction

endpackage

// File: rtl/jtag_vector_player_tck_gen.sv
// TCK generator: half-period counter, TCK phase, TDO sample strobe and end-of-cycle flag.
module jtag_tck_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] half_w,
    input  logic [31:0] sample_idx,
    output logic        tck,
    output logic        sample,
    output logic        cycle_end
);

    logic [31:0] cnt_q;
    logic        phase_q;
    logic        last_clk;

    assign last_clk = (cnt_q == half_w - 32'd1);

    // Disabling parks TCK low, so FETCH/STORE simply stretch the low phase.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (last_clk) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign tck       = phase_q;
    assign sample    = en && phase_q && (cnt_q == sample_idx);
    assign cycle_end = en && phase_q && last_clk;

endmodule

// File: rtl/jtag_vector_player.sv
// Plays TMS/TDI vectors from RAM 1 onto the JTAG pins and captures TDO into RAM 2.
// Optional: define JTAG_PLAYER_TDO_SYNC_EN to add a 2-flop synchronizer on jtag_tdo.
module jtag_vector_player
    import jtag_vector_player_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  cycle_count,
    input  logic [31:0]       tck_width,
    input  logic [31:0]       tdo_delay,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vector_1_addr,
    input  logic [7:0]        vector_1_rd_data,
    output logic [ADDR_W-1:0] vector_2_addr,
    output logic              vector_2_we,
    output logic [7:0]        vector_2_wr_data,
    output logic              jtag_tck,
    output logic              jtag_tms,
    output logic              jtag_tdi,
    input  logic              jtag_tdo
);

    state_e                   state_q;
    logic [CNT_W-1:0]         rem_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     fetch_cnt_q;
    logic [1:0]               lane_q;
    logic                     busy_q, done_q, we_q, tms_q, tdi_q;
    logic [7:0]               wr_data_q;
    logic [7:0]               byte_q;
    logic [31:0]              half_w_q, sample_idx_q;
    logic [BITS_PER_BYTE-1:0] tdo_q, tdo_d;
    logic [31:0]              w_start, idx_start;
    logic                     tdo_s, shift_en, sample, cycle_end, last_bit, accept;

`ifdef JTAG_PLAYER_TDO_SYNC_EN
    logic [1:0] tdo_sync_q;
    always_ff @(posedge clk) begin
        tdo_sync_q <= {tdo_sync_q[0], jtag_tdo};
    end
    assign tdo_s = tdo_sync_q[1];
`else
    assign tdo_s = jtag_tdo;
`endif

    assign w_start   = (tck_width == 32'd0) ? 32'd1 : tck_width;
    assign idx_start = (tdo_delay >= w_start) ? (w_start - 32'd1) : tdo_delay;
    assign accept    = (state_q == ST_IDLE) && start && !done_q;
    assign shift_en  = (state_q == ST_SHIFT);
    assign last_bit  = (lane_q == 2'(BITS_PER_BYTE - 1)) || (rem_q == CNT_W'(1));

    jtag_tck_gen u_tck_gen (
        .clk        (clk),
        .reset      (reset),
        .en         (shift_en),
        .half_w     (half_w_q),
        .sample_idx (sample_idx_q),
        .tck        (jtag_tck),
        .sample     (sample),
        .cycle_end  (cycle_end)
    );

    // Merge a same-cycle sample so the final bit reaches the STORE write data.
    always_comb begin
        tdo_d = tdo_q;
        if (sample) tdo_d[lane_q] = tdo_s;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            half_w_q     <= w_start;
            sample_idx_q <= idx_start;
        end
        if (state_q == ST_FETCH) begin
            tdo_q  <= '0;
            byte_q <= vector_1_rd_data;
        end else if (sample) begin
            tdo_q <= tdo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            addr_q      <= '0;
            fetch_cnt_q <= 1'b0;
            lane_q      <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            wr_data_q   <= 8'd0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (cycle_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= ST_FETCH;
                            busy_q      <= 1'b1;
                            rem_q       <= cycle_count;
                            addr_q      <= '0;
                            fetch_cnt_q <= 1'b0;
                        end
                    end
                end
                ST_FETCH: begin
                    if (fetch_cnt_q == 1'(FETCH_CYCLES - 1)) begin
                        fetch_cnt_q      <= 1'b0;
                        lane_q           <= 2'd0;
                        {tdi_q, tms_q}   <= lane_pins(vector_1_rd_data, 2'd0);
                        state_q          <= ST_SHIFT;
                    end else begin
                        fetch_cnt_q <= fetch_cnt_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cycle_end) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (last_bit) begin
                            state_q   <= ST_STORE;
                            we_q      <= 1'b1;
                            wr_data_q <= {{(8 - BITS_PER_BYTE){1'b0}}, tdo_d};
                        end else begin
                            lane_q         <= lane_q + 2'd1;
                            {tdi_q, tms_q} <= lane_pins(byte_q, lane_q + 2'd1);
                        end
                    end
                end
                ST_STORE: begin
                    if (rem_q != '0) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign vector_1_addr    = addr_q;
    assign vector_2_addr    = addr_q;
    assign vector_2_we      = we_q;
    assign vector_2_wr_data = wr_data_q;
    assign jtag_tms         = tms_q;
    assign jtag_tdi         = tdi_q;

endmodule

// File: tb/tb_jtag_vector_player.sv
// Directed self-checking bench for jtag_vector_player with RAM and TDO target models.
module tb_jtag_vector_player;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 15;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [CNT_W-1:0]  cycle_count;
    logic [31:0]       tck_width, tdo_delay;
    logic              busy, done;
    logic [ADDR_W-1:0] vector_1_addr, vector_2_addr;
    logic [7:0]        vector_1_rd_data, vector_2_wr_data;
    logic              vector_2_we;
    logic              jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;

    int checks   = 0;
    int failures = 0;

    jtag_vector_player #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .cycle_count      (cycle_count),
        .tck_width        (tck_width),
        .tdo_delay        (tdo_delay),
        .busy             (busy),
        .done             (done),
        .vector_1_addr    (vector_1_addr),
        .vector_1_rd_data (vector_1_rd_data),
        .vector_2_addr    (vector_2_addr),
        .vector_2_we      (vector_2_we),
        .vector_2_wr_data (vector_2_wr_data),
        .jtag_tck         (jtag_tck),
        .jtag_tms         (jtag_tms),
        .jtag_tdi         (jtag_tdi),
        .jtag_tdo         (jtag_tdo)
    );

    always #5 clk = ~clk;

    // RAM 1: synchronous read, one clk latency.
    logic [7:0] ram1 [0:15];
    always @(posedge clk) vector_1_rd_data <= ram1[vector_1_addr[3:0]];

    // TCK-cycle monitor and per-cycle TDO pattern target.
    int   rises = 0;
    int   rb = 0;
    time  rise_t  [0:63];
    logic tms_log [0:63];
    logic tdi_log [0:63];
    logic pat     [0:63];
    logic tdo_a = 1'b0;
    logic tdo_b = 1'b0;
    int   mode  = 0;
    int   hc    = 0;

    always @(posedge jtag_tck) begin
        rise_t [(rises - rb) & 63] = $time;
        tms_log[(rises - rb) & 63] = jtag_tms;
        tdi_log[(rises - rb) & 63] = jtag_tdi;
        tdo_a = pat[(rises - rb) & 63];
        rises++;
    end

    assign jtag_tdo = (mode == 1) ? tdo_b : tdo_a;

    // Pulse/write monitor sampled mid-cycle; mode 1 drives TDO high only on the 3rd high clk.
    int         done_cnt = 0;
    int         wr_cnt   = 0;
    logic [ADDR_W-1:0] wa_log [0:15];
    logic [7:0]        wd_log [0:15];

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (vector_2_we === 1'b1) begin
            wa_log[wr_cnt & 15] = vector_2_addr;
            wd_log[wr_cnt & 15] = vector_2_wr_data;
            wr_cnt++;
        end
        if (jtag_tck === 1'b1) hc++;
        else hc = 0;
        tdo_b = (hc == 3);
    end

    time t_start;

    task automatic run_start(input int cnt, input int w, input int dly);
        @(negedge clk);
        cycle_count = CNT_W'(cnt);
        tck_width   = w;
        tdo_delay   = dly;
        start       = 1'b1;
        @(posedge clk);
        t_start = $time;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s: done not seen within %0d cycles, required a done pulse", name, budget);
        end
    endtask

    task automatic set_pat_all(input logic v);
        for (int i = 0; i < 64; i++) pat[i] = v;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        cycle_count = '0;
        tck_width = 32'd2;
        tdo_delay = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, vector_2_we, jtag_tck, jtag_tms, jtag_tdi} !== 6'b000010) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000010",
                     {busy, done, vector_2_we, jtag_tck, jtag_tms, jtag_tdi});
        end
        checks++;
        if ({vector_1_addr, vector_2_addr, vector_2_wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_data: got a1=%h a2=%h wd=%h want 0", vector_1_addr, vector_2_addr, vector_2_wr_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int wb, db;
        ram1[0] = 8'hB4;
        set_pat_all(1'b1);
        mode = 0;
        rb = rises; wb = wr_cnt; db = done_cnt;
        run_start(4, 2, 0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(200, "basic_done");
        repeat (5) @(negedge clk);
        checks++;
        if (rises - rb != 4) begin failures++; $display("FAIL basic_rises: got %0d want 4", rises - rb); end
        checks++;
        if ({tms_log[0], tms_log[1], tms_log[2], tms_log[3]} !== 4'b0110) begin
            failures++;
            $display("FAIL basic_tms: got %b want 0110", {tms_log[0], tms_log[1], tms_log[2], tms_log[3]});
        end
        checks++;
        if ({tdi_log[0], tdi_log[1], tdi_log[2], tdi_log[3]} !== 4'b0011) begin
            failures++;
            $display("FAIL basic_tdi: got %b want 0011", {tdi_log[0], tdi_log[1], tdi_log[2], tdi_log[3]});
        end
        checks++;
        if (rise_t[1] - rise_t[0] != 40) begin
            failures++;
            $display("FAIL basic_period: got %0t want 40", rise_t[1] - rise_t[0]);
        end
        checks++;
        if (rise_t[0] - t_start != 40) begin
            failures++;
            $display("FAIL basic_latency: got %0t want 40", rise_t[0] - t_start);
        end
        checks++;
        if (wr_cnt - wb != 1 || wa_log[wb & 15] !== '0 || wd_log[wb & 15] !== 8'h0F) begin
            failures++;
            $display("FAIL basic_write: got n=%0d a=%h d=%h want n=1 a=0 d=0f",
                     wr_cnt - wb, wa_log[wb & 15], wd_log[wb & 15]);
        end
        checks++;
        if (done_cnt - db != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_once: got dones=%0d busy=%b want 1,0", done_cnt - db, busy);
        end
        checks++;
        if ({jtag_tms, jtag_tdi} !== 2'b01) begin
            failures++;
            $display("FAIL basic_hold: got tms,tdi=%b want 01", {jtag_tms, jtag_tdi});
        end
    endtask

    task automatic test_multi_byte;
        int wb;
        logic tp [0:5];
        tp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ram1[0] = 8'h1B;
        ram1[1] = 8'h2D;
        for (int i = 0; i < 6; i++) pat[i] = tp[i];
        mode = 0;
        rb = rises; wb = wr_cnt;
        run_start(6, 2, 0);
        wait_done(300, "multi_done");
        repeat (5) @(negedge clk);
        checks++;
        if (wr_cnt - wb != 2) begin failures++; $display("FAIL multi_nwrites: got %0d want 2", wr_cnt - wb); end
        checks++;
        if (wa_log[wb & 15] !== 12'd0 || wd_log[wb & 15] !== 8'h05) begin
            failures++;
            $display("FAIL multi_byte0: got a=%h d=%h want a=0 d=05", wa_log[wb & 15], wd_log[wb & 15]);
        end
        checks++;
        if (wa_log[(wb + 1) & 15] !== 12'd1 || wd_log[(wb + 1) & 15] !== 8'h03) begin
            failures++;
            $display("FAIL multi_byte1: got a=%h d=%h want a=1 d=03", wa_log[(wb + 1) & 15], wd_log[(wb + 1) & 15]);
        end
        checks++;
        if ({tms_log[4], tms_log[5], tdi_log[4], tdi_log[5]} !== 4'b1101) begin
            failures++;
            $display("FAIL multi_pins_b1: got %b want 1101", {tms_log[4], tms_log[5], tdi_log[4], tdi_log[5]});
        end
        checks++;
        if (rise_t[4] - rise_t[3] != 70) begin
            failures++;
            $display("FAIL multi_overhead: got %0t want 70", rise_t[4] - rise_t[3]);
        end
    endtask

    task automatic test_zero_count;
        int wb, db, r0;
        wb = wr_cnt; db = done_cnt; r0 = rises;
        @(negedge clk);
        cycle_count = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b10) begin
            failures++;
            $display("FAIL zero_done: got done,busy=%b want 10", {done, busy});
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt - db != 1 || wr_cnt != wb || rises != r0) begin
            failures++;
            $display("FAIL zero_quiet: got dones=%0d writes=%0d rises=%0d want 1,0,0",
                     done_cnt - db, wr_cnt - wb, rises - r0);
        end
    endtask

    task automatic test_width_zero;
        int wb;
        ram1[0] = 8'hB4;
        set_pat_all(1'b1);
        mode = 0;
        for (int k = 0; k < 2; k++) begin
            rb = rises; wb = wr_cnt;
            run_start(4, k, 0);
            wait_done(200, "w01_done");
            repeat (3) @(negedge clk);
            checks++;
            if (rise_t[1] - rise_t[0] != 20 || rise_t[0] - t_start != 30) begin
                failures++;
                $display("FAIL w01_timing w=%0d: got period=%0t lat=%0t want 20,30",
                         k, rise_t[1] - rise_t[0], rise_t[0] - t_start);
            end
            checks++;
            if (wr_cnt - wb != 1 || wd_log[wb & 15] !== 8'h0F) begin
                failures++;
                $display("FAIL w01_data w=%0d: got n=%0d d=%h want 1,0f", k, wr_cnt - wb, wd_log[wb & 15]);
            end
        end
    endtask

    task automatic test_tdo_delay;
        int wb;
        ram1[0] = 8'h00;
        mode = 1;
        rb = rises; wb = wr_cnt;
        run_start(4, 3, 100);
        wait_done(300, "delay_done");
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt - wb != 1 || wd_log[wb & 15] !== 8'h0F) begin
            failures++;
            $display("FAIL delay_sample: got n=%0d d=%h want 1,0f", wr_cnt - wb, wd_log[wb & 15]);
        end
        checks++;
        if (rise_t[1] - rise_t[0] != 60) begin
            failures++;
            $display("FAIL delay_period: got %0t want 60", rise_t[1] - rise_t[0]);
        end
        mode = 0;
    endtask

    task automatic test_back_to_back;
        int wb, db;
        ram1[0] = 8'hB4;
        set_pat_all(1'b1);
        rb = rises; wb = wr_cnt; db = done_cnt;
        run_start(4, 2, 0);
        repeat (5) @(negedge clk);
        cycle_count = CNT_W'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, "b2b_done");
        cycle_count = CNT_W'(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt - db != 1 || wr_cnt - wb != 1 || rises - rb != 4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ignored: got dones=%0d writes=%0d rises=%0d busy=%b want 1,1,4,0",
                     done_cnt - db, wr_cnt - wb, rises - rb, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int wb, db, n;
        ram1[0] = 8'h00;
        ram1[1] = 8'hFF;
        set_pat_all(1'b1);
        rb = rises; wb = wr_cnt; db = done_cnt;
        run_start(8, 2, 0);
        n = 0;
        while (rises - rb < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rises - rb < 5) begin
            failures++;
            $display("FAIL midrst_reach: got rises=%0d want 5 within 200 cycles", rises - rb);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, vector_2_we, jtag_tck, jtag_tms, jtag_tdi} !== 6'b000010) begin
            failures++;
            $display("FAIL midrst_ctrl: got %b want 000010",
                     {busy, done, vector_2_we, jtag_tck, jtag_tms, jtag_tdi});
        end
        checks++;
        if ({vector_1_addr, vector_2_addr, vector_2_wr_data} !== '0) begin
            failures++;
            $display("FAIL midrst_data: got a1=%h a2=%h wd=%h want 0", vector_1_addr, vector_2_addr, vector_2_wr_data);
        end
        reset = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (wr_cnt - wb != 1 || wa_log[wb & 15] !== 12'd0 || done_cnt != db || rises - rb != 5) begin
            failures++;
            $display("FAIL midrst_after: got writes=%0d a=%h dones=%0d rises=%0d want 1,0,0,5",
                     wr_cnt - wb, wa_log[wb & 15], done_cnt - db, rises - rb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_byte();
        test_zero_count();
        test_width_zero();
        test_tdo_delay();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
